memory_bus_adapter: RTL and testbench
=====================================

# memory_bus_adapter

Sits directly downstream of the load/store reservation unit. Serves its `memory_*` request/ready handshake against a word-organised data RAM with byte enables and a variable-latency ready handshake. Converts byte-addressed byte/half/word accesses into one or two aligned word accesses, splitting misaligned accesses across a word boundary. Returns load data right-aligned and zero-filled above the access size; the requester applies sign extension.

## Interface
- `SIZE`, 32: data/address width; must be 32 (4 bytes per word)
- `clock` input 1: sole clock, rising edge
- `reset` input 1: synchronous, active-high
- `memory_enable` input 1: request valid; held with stable fields until `memory_ready`
- `memory_operation` input 1: 0 = load, 1 = store
- `memory_data_size` input 2: 0 byte, 1 half, 2 word, 3 invalid
- `memory_address` input SIZE: byte address
- `memory_data_out` input SIZE: store data, right-aligned (requester's output)
- `memory_ready` output 1: one-cycle completion pulse
- `memory_data_in` output SIZE: load result to requester, valid while `memory_ready`=1, held until next completion
- `ram_enable` output 1: RAM request valid
- `ram_write` output 1: 1 = write
- `ram_address` output SIZE-2: word address
- `ram_byte_enable` output 4: write byte lanes, bit i = bits 8i+7:8i
- `ram_write_data` output SIZE: lane-aligned write data
- `ram_read_data` input SIZE: read word, valid when `ram_ready`=1
- `ram_ready` input 1: RAM accepts/completes the current request this cycle

## Operation
- States: IDLE, FIRST, SECOND, RESPOND.
- IDLE: if `memory_enable`, capture operation, size, address, store data; bytes n = 1/2/4 for size 0/1/2; offset o = address[1:0]. Size 3 goes to RESPOND with result 0 and no RAM access. Otherwise go to FIRST.
- split = (o + n > 4).
- FIRST: `ram_enable`=1, `ram_address` = address[SIZE-1:2]. On `ram_ready`, store word0 from `ram_read_data`, then go to SECOND if split, else RESPOND.
- SECOND: `ram_address` = word address + 1, wrapping modulo 2^(SIZE-2). On `ram_ready`, store word1 and go to RESPOND.
- RESPOND: `memory_ready`=1 for exactly one cycle, then IDLE. A request still asserted in the following IDLE cycle is a new request.
- Store lanes:
  - mask8 = ((1<<n)-1) << o, 8 bits.
  - FIRST byte enable = mask8[3:0]; SECOND byte enable = mask8[7:4].
  - wide = {32'b0, data} << 8·o.
  - FIRST write data = wide[31:0]; SECOND write data = wide[63:32].
- Load result: ({word1, word0} >> 8·o)[31:0], with bytes ≥ n cleared. word1 = 0 when not split.
- Stores return `memory_data_in` = 0.
- `ram_write` = captured operation; `ram_byte_enable` = 0 for loads.
- All `ram_*` outputs are stable while `ram_enable`=1 and `ram_ready`=0.
- Request inputs are ignored outside IDLE.

## Timing
- Reset values: state IDLE; `memory_ready` 0, `memory_data_in` 0, `ram_enable` 0, `ram_write` 0, `ram_address` 0, `ram_byte_enable` 0, `ram_write_data` 0.
- All outputs are registered or decoded from state. No combinational path from `ram_ready` to `ram_enable`.
- Latency with zero-wait RAM (`ram_ready` high in the first cycle of `ram_enable`):
  - enable seen in cycle 0 → FIRST in cycle 1 → `memory_ready` in cycle 2 (aligned);
  - `memory_ready` in cycle 3 (split).
- Each RAM wait cycle adds one cycle.
- Size 3: `memory_ready` in cycle 1.
- `memory_ready` never asserts on two consecutive cycles. The requester's completion logic depends on this.
- Reset mid-transaction: the next cycle is IDLE with all outputs at reset values. An outstanding RAM request is abandoned and no `memory_ready` is produced.
- Back-to-back requests: minimum spacing is one IDLE cycle between a RESPOND and the next FIRST.

## Test plan
- Aligned word load: addr 0x100, size 2, RAM word 0x100 = 0xDEADBEEF, zero-wait → one RAM read at word address 0x40; `memory_ready` in cycle 2 with `memory_data_in` 0xDEADBEEF.
- Byte load: addr 0x103, size 0, word = 0x80FF1122 → `memory_data_in` 0x00000080; no second access.
- Misaligned half store: addr 0x1003, data 0x0000ABCD → write 1 at word 0x400, byte enable 4'b1000, data 0xCD000000; write 2 at word 0x401, byte enable 4'b0001, data 0x000000AB; `memory_ready` in cycle 3.
- Misaligned word load across the top of memory, with 2 wait cycles per access: addr 0xFFFFFFFE, word 0x3FFFFFFF = 0x1234xxxx, word 0 = 0xyyyy5678 → second `ram_address` 0; result 0x56781234; `memory_ready` in cycle 7, high for one cycle only.
- Reset during SECOND: assert `reset` for one cycle → all outputs at reset values; a following aligned load completes normally.
- Size 3 request, then an immediate aligned store → no RAM access for the first; `memory_ready` pulses, returns to IDLE, then the store proceeds with byte enable 4'b1111.

Source files
------------

// File: rtl/memory_bus_adapter.sv
// memory_bus_adapter
// Bridges the reservation unit's byte-addressed load/store handshake to a
// word-organised RAM with byte enables and a variable-latency ready.
// Misaligned accesses that cross a word boundary become two word accesses.
//
// Ports:
//   clock, reset          - rising-edge clock, synchronous active-high reset
//   memory_enable/_operation/_data_size/_address/_data_out
//                         - request side (held stable until memory_ready)
//   memory_ready          - one-cycle completion pulse
//   memory_data_in        - right-aligned, zero-filled load result (0 for stores)
//   ram_enable/_write/_address/_byte_enable/_write_data
//                         - RAM request, stable until ram_ready
//   ram_read_data, ram_ready
//                         - RAM response
module memory_bus_adapter #(
  parameter int unsigned SIZE = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              memory_enable,
  input  logic              memory_operation,
  input  logic [1:0]        memory_data_size,
  input  logic [SIZE-1:0]   memory_address,
  input  logic [SIZE-1:0]   memory_data_out,
  output logic              memory_ready,
  output logic [SIZE-1:0]   memory_data_in,
  output logic              ram_enable,
  output logic              ram_write,
  output logic [SIZE-3:0]   ram_address,
  output logic [3:0]        ram_byte_enable,
  output logic [SIZE-1:0]   ram_write_data,
  input  logic [SIZE-1:0]   ram_read_data,
  input  logic              ram_ready
);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond, StRespond} state_e;

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic [2:0]        bytes_q, bytes_d;
  logic [1:0]        offset_q, offset_d;
  logic [SIZE-3:0]   word_addr_q, word_addr_d;
  logic [SIZE-1:0]   wdata_q, wdata_d;
  logic [SIZE-1:0]   word0_q, word0_d;
  logic [SIZE-1:0]   rdata_q, rdata_d;

  logic              split;
  logic [7:0]        mask_base, mask8;
  logic [2*SIZE-1:0] wide;
  logic [SIZE-1:0]   byte_mask, load_lo, load_hi, load_result;
  logic [4:0]        shamt;

  assign shamt = {offset_q, 3'b000};
  assign split = (({1'b0, offset_q} + bytes_q) > 3'd4);

  // Lane mask and shifted store data spanning two words; upper half feeds SECOND.
  always_comb begin
    mask_base = 8'h00;
    byte_mask = '0;
    case (bytes_q)
      3'd1: begin mask_base = 8'h01; byte_mask = SIZE'(32'h0000_00ff); end
      3'd2: begin mask_base = 8'h03; byte_mask = SIZE'(32'h0000_ffff); end
      3'd4: begin mask_base = 8'h0f; byte_mask = '1; end
      default: ;
    endcase
  end

  assign mask8 = mask_base << offset_q;
  assign wide  = {{SIZE{1'b0}}, wdata_q} << shamt;

  // In FIRST the incoming word is word0 (word1 = 0); in SECOND it is word1.
  assign load_lo     = (state_q == StSecond) ? word0_q : ram_read_data;
  assign load_hi     = (state_q == StSecond) ? ram_read_data : '0;
  assign load_result = SIZE'({load_hi, load_lo} >> shamt) & byte_mask;

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    bytes_d     = bytes_q;
    offset_d    = offset_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    word0_d     = word0_q;
    rdata_d     = rdata_q;
    case (state_q)
      StIdle: begin
        if (memory_enable) begin
          op_d        = memory_operation;
          offset_d    = memory_address[1:0];
          word_addr_d = memory_address[SIZE-1:2];
          wdata_d     = memory_data_out;
          case (memory_data_size)
            2'd0:    bytes_d = 3'd1;
            2'd1:    bytes_d = 3'd2;
            2'd2:    bytes_d = 3'd4;
            default: bytes_d = 3'd0;
          endcase
          if (memory_data_size == 2'd3) begin
            rdata_d = '0;
            state_d = StRespond;
          end else begin
            state_d = StFirst;
          end
        end
      end
      StFirst: begin
        if (ram_ready) begin
          word0_d = ram_read_data;
          if (split) begin
            state_d = StSecond;
          end else begin
            rdata_d = op_q ? '0 : load_result;
            state_d = StRespond;
          end
        end
      end
      StSecond: begin
        if (ram_ready) begin
          rdata_d = op_q ? '0 : load_result;
          state_d = StRespond;
        end
      end
      StRespond: state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 1'b0;
      bytes_q     <= 3'd0;
      offset_q    <= 2'd0;
      word_addr_q <= '0;
      wdata_q     <= '0;
      word0_q     <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      bytes_q     <= bytes_d;
      offset_q    <= offset_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      word0_q     <= word0_d;
      rdata_q     <= rdata_d;
    end
  end

  // Outputs decode from state and captured request only, so they hold
  // steady across RAM wait cycles and never depend on ram_ready.
  always_comb begin
    memory_ready    = (state_q == StRespond);
    memory_data_in  = rdata_q;
    ram_enable      = 1'b0;
    ram_write       = 1'b0;
    ram_address     = '0;
    ram_byte_enable = 4'b0000;
    ram_write_data  = '0;
    if (state_q == StFirst) begin
      ram_enable      = 1'b1;
      ram_write       = op_q;
      ram_address     = word_addr_q;
      ram_byte_enable = op_q ? mask8[3:0] : 4'b0000;
      ram_write_data  = wide[SIZE-1:0];
    end else if (state_q == StSecond) begin
      ram_enable      = 1'b1;
      ram_write       = op_q;
      ram_address     = word_addr_q + 1'b1;
      ram_byte_enable = op_q ? mask8[7:4] : 4'b0000;
      ram_write_data  = wide[2*SIZE-1:SIZE];
    end
  end

endmodule

// File: tb/tb_memory_bus_adapter.sv
module tb_memory_bus_adapter;

  logic        clock = 1'b0;
  logic        reset;
  logic        memory_enable;
  logic        memory_operation;
  logic [1:0]  memory_data_size;
  logic [31:0] memory_address;
  logic [31:0] memory_data_out;
  logic        memory_ready;
  logic [31:0] memory_data_in;
  logic        ram_enable;
  logic        ram_write;
  logic [29:0] ram_address;
  logic [3:0]  ram_byte_enable;
  logic [31:0] ram_write_data;
  logic [31:0] ram_read_data;
  logic        ram_ready;

  int passes = 0;
  int total  = 0;

  always #5 clock = ~clock;

  memory_bus_adapter #(.SIZE(32)) dut (
    .clock            (clock),
    .reset            (reset),
    .memory_enable    (memory_enable),
    .memory_operation (memory_operation),
    .memory_data_size (memory_data_size),
    .memory_address   (memory_address),
    .memory_data_out  (memory_data_out),
    .memory_ready     (memory_ready),
    .memory_data_in   (memory_data_in),
    .ram_enable       (ram_enable),
    .ram_write        (ram_write),
    .ram_address      (ram_address),
    .ram_byte_enable  (ram_byte_enable),
    .ram_write_data   (ram_write_data),
    .ram_read_data    (ram_read_data),
    .ram_ready        (ram_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic req(input logic op, input logic [1:0] sz, input logic [31:0] a,
                     input logic [31:0] d);
    memory_enable    = 1'b1;
    memory_operation = op;
    memory_data_size = sz;
    memory_address   = a;
    memory_data_out  = d;
  endtask

  task automatic chk_ram(input string tag, input logic en, input logic wr,
                         input logic [29:0] a, input logic [3:0] be, input logic [31:0] wd);
    chk({tag, ".en"}, {31'b0, ram_enable}, {31'b0, en});
    chk({tag, ".wr"}, {31'b0, ram_write}, {31'b0, wr});
    chk({tag, ".addr"}, {2'b0, ram_address}, {2'b0, a});
    chk({tag, ".be"}, {28'b0, ram_byte_enable}, {28'b0, be});
    chk({tag, ".wdata"}, ram_write_data, wd);
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    chk(tag, {31'b0, memory_ready}, {31'b0, r});
  endtask

  initial begin
    reset = 1'b1;
    memory_enable = 1'b0; memory_operation = 1'b0; memory_data_size = 2'd0;
    memory_address = '0; memory_data_out = '0;
    ram_read_data = '0; ram_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    // Reset state
    chk_rdy("rst.ready", 1'b0);
    chk("rst.data_in", memory_data_in, 32'h0);
    chk_ram("rst", 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);

    // Aligned word load, zero-wait
    req(1'b0, 2'd2, 32'h0000_0100, 32'h0);                   // cycle 0
    step();                                                   // cycle 1
    chk_ram("wl.first", 1'b1, 1'b0, 30'h40, 4'h0, 32'h0);
    chk_rdy("wl.c1.ready", 1'b0);
    ram_ready = 1'b1; ram_read_data = 32'hDEAD_BEEF;
    step();                                                   // cycle 2
    chk_rdy("wl.c2.ready", 1'b1);
    chk("wl.data", memory_data_in, 32'hDEAD_BEEF);
    chk("wl.c2.ram_en", {31'b0, ram_enable}, 32'h0);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();
    chk_rdy("wl.c3.ready", 1'b0);
    chk("wl.held", memory_data_in, 32'hDEAD_BEEF);

    // Byte load, offset 3
    req(1'b0, 2'd0, 32'h0000_0103, 32'h0);
    step();
    chk_ram("bl.first", 1'b1, 1'b0, 30'h40, 4'h0, 32'h0);
    ram_ready = 1'b1; ram_read_data = 32'h80FF_1122;
    step();
    chk_rdy("bl.ready", 1'b1);
    chk("bl.data", memory_data_in, 32'h0000_0080);
    chk("bl.no_second", {31'b0, ram_enable}, 32'h0);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();

    // Misaligned half store across a word boundary
    req(1'b1, 2'd1, 32'h0000_1003, 32'h0000_ABCD);
    step();
    chk_ram("hs.first", 1'b1, 1'b1, 30'h400, 4'b1000, 32'hCD00_0000);
    ram_ready = 1'b1;
    step();
    chk_ram("hs.second", 1'b1, 1'b1, 30'h401, 4'b0001, 32'h0000_00AB);
    chk_rdy("hs.c2.ready", 1'b0);
    step();
    chk_rdy("hs.c3.ready", 1'b1);
    chk("hs.data", memory_data_in, 32'h0);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();
    chk_rdy("hs.c4.ready", 1'b0);

    // Misaligned word load wrapping the top of memory, 2 wait cycles each
    req(1'b0, 2'd2, 32'hFFFF_FFFE, 32'h0);
    step();                                                   // cycle 1
    chk_ram("wr.c1", 1'b1, 1'b0, 30'h3FFF_FFFF, 4'h0, 32'h0);
    step();                                                   // cycle 2
    chk_ram("wr.c2.stable", 1'b1, 1'b0, 30'h3FFF_FFFF, 4'h0, 32'h0);
    step();                                                   // cycle 3
    ram_ready = 1'b1; ram_read_data = 32'h1234_ABCD;
    step();                                                   // cycle 4
    ram_ready = 1'b0; ram_read_data = 32'h0;
    chk_ram("wr.c4.second", 1'b1, 1'b0, 30'h0, 4'h0, 32'h0);
    step();                                                   // cycle 5
    chk_rdy("wr.c5.ready", 1'b0);
    step();                                                   // cycle 6
    chk_rdy("wr.c6.ready", 1'b0);
    ram_ready = 1'b1; ram_read_data = 32'hEF01_5678;
    step();                                                   // cycle 7
    chk_rdy("wr.c7.ready", 1'b1);
    chk("wr.data", memory_data_in, 32'h5678_1234);
    ram_ready = 1'b1;                                          // stray ready must not matter
    step();                                                   // cycle 8
    chk_rdy("wr.c8.ready", 1'b0);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();

    // Reset during SECOND
    req(1'b0, 2'd1, 32'h0000_1003, 32'h0);
    step();
    ram_ready = 1'b1; ram_read_data = 32'hAA00_0000;
    step();
    chk_ram("rs.second", 1'b1, 1'b0, 30'h401, 4'h0, 32'h0);
    reset = 1'b1; ram_ready = 1'b0; memory_enable = 1'b0;
    step();
    reset = 1'b0;
    chk_rdy("rs.ready", 1'b0);
    chk("rs.data_in", memory_data_in, 32'h0);
    chk_ram("rs.ram", 1'b0, 1'b0, 30'h0, 4'h0, 32'h0);
    step();
    chk_rdy("rs.idle.ready", 1'b0);
    req(1'b0, 2'd2, 32'h0000_0008, 32'h0);
    step();
    chk_ram("rs.load", 1'b1, 1'b0, 30'h2, 4'h0, 32'h0);
    ram_ready = 1'b1; ram_read_data = 32'h1122_3344;
    step();
    chk_rdy("rs.load.ready", 1'b1);
    chk("rs.load.data", memory_data_in, 32'h1122_3344);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();

    // Size 3, then an immediate aligned store
    req(1'b0, 2'd3, 32'h0000_0044, 32'h0);
    step();                                                   // cycle 1: RESPOND
    chk_rdy("s3.ready", 1'b1);
    chk("s3.data", memory_data_in, 32'h0);
    chk("s3.no_ram", {31'b0, ram_enable}, 32'h0);
    req(1'b1, 2'd2, 32'h0000_0020, 32'hCAFE_F00D);
    step();                                                   // cycle 2: IDLE
    chk_rdy("s3.idle.ready", 1'b0);
    chk("s3.idle.ram", {31'b0, ram_enable}, 32'h0);
    step();                                                   // cycle 3: FIRST
    chk_ram("st.first", 1'b1, 1'b1, 30'h8, 4'b1111, 32'hCAFE_F00D);
    ram_ready = 1'b1;
    step();
    chk_rdy("st.ready", 1'b1);
    chk("st.data", memory_data_in, 32'h0);
    memory_enable = 1'b0; ram_ready = 1'b0;
    step();
    chk_rdy("st.after", 1'b0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
